// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants, mux encodings and FSM state type for the EX issue controller
package ex_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_MUL = 5'd16;
  localparam logic [4:0] ALU_DIV = 5'd17;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// rtl/ex_issue_ctrl_if.sv - decode/EX bundle; perf counters present under EX_ISSUE_CTRL_PERF_EN
interface ex_issue_ctrl_if
`ifdef EX_ISSUE_CTRL_PERF_EN
  #(parameter int PERF_W = 32)
`endif
  ;
  import ex_pkg::*;

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_we_i;
  logic              id_load_i;
  logic              id_use_imm_i;
  logic              id_mc_i;
  logic [4:0]        id_alu_op_i;
  logic              flush_i;
  logic              stall_o;
  logic              ex_valid_o;
  logic [4:0]        alu_op_o;
  logic [1:0]        mux1_o;
  logic [1:0]        mux2_o;
  logic              mux3_o;
  logic              mc_done_o;
`ifdef EX_ISSUE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_lu_stalls_o;
  logic [PERF_W-1:0] perf_mc_stalls_o;
`endif

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_we_i, id_load_i,
           id_use_imm_i, id_mc_i, id_alu_op_i, flush_i,
    input  stall_o, ex_valid_o, alu_op_o, mux1_o, mux2_o, mux3_o, mc_done_o
`ifdef EX_ISSUE_CTRL_PERF_EN
           , perf_lu_stalls_o, perf_mc_stalls_o
`endif
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_we_i, id_load_i,
           id_use_imm_i, id_mc_i, id_alu_op_i, flush_i,
    output stall_o, ex_valid_o, alu_op_o, mux1_o, mux2_o, mux3_o, mc_done_o
`ifdef EX_ISSUE_CTRL_PERF_EN
           , perf_lu_stalls_o, perf_mc_stalls_o
`endif
  );

endinterface

// File: rtl/ex_fwd_sel.sv
// rtl/ex_fwd_sel.sv - per-operand forwarding select; the younger EX-stage producer beats MEM
module ex_fwd_sel
  import ex_pkg::*;
(
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_we_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = SEL_RF;
    if (rs_i != '0) begin
      if (ex_we_i && (rs_i == ex_rd_i)) begin
        sel_o = SEL_EXMEM;
      end else if (mem_we_i && (rs_i == mem_rd_i)) begin
        sel_o = SEL_MEMWB;
      end
    end
  end

endmodule

// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - ID->EX issue, forwarding selects, load-use stall and multi-cycle hold
// Optional stall counters are built when EX_ISSUE_CTRL_PERF_EN is defined.
module ex_issue_ctrl
  import ex_pkg::*;
#(
  parameter int MC_CYCLES = 4
`ifdef EX_ISSUE_CTRL_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input logic            clk,
  input logic            rst,
  ex_issue_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MC_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        alu_op_q, alu_op_d;
  logic [1:0]        mux1_q, mux1_d, mux2_q, mux2_d;
  logic              mux3_q, mux3_d;
  logic              mc_done_q, mc_done_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic              ex_we_q, ex_we_d, ex_load_q, ex_load_d, mem_we_q, mem_we_d;
  logic [1:0]        fwd1, fwd2;
  logic              issue_slot, lu_hazard, stall;

  ex_fwd_sel u_fwd1 (.rs_i(bus.id_rs1_i), .ex_rd_i(ex_rd_q), .ex_we_i(ex_we_q),
                     .mem_rd_i(mem_rd_q), .mem_we_i(mem_we_q), .sel_o(fwd1));
  ex_fwd_sel u_fwd2 (.rs_i(bus.id_rs2_i), .ex_rd_i(ex_rd_q), .ex_we_i(ex_we_q),
                     .mem_rd_i(mem_rd_q), .mem_we_i(mem_we_q), .sel_o(fwd2));

  // rs2 is not a real source when the immediate replaces operand 2
  assign lu_hazard = bus.id_valid_i && ex_load_q && (ex_rd_q != '0) &&
                     ((bus.id_rs1_i == ex_rd_q) ||
                      (!bus.id_use_imm_i && (bus.id_rs2_i == ex_rd_q)));

  // The MC_BUSY cycle with the counter at zero is the exit cycle and issues like RUN
  assign issue_slot = (state_q != MC_BUSY) || (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_valid_d = ex_valid_q;
    alu_op_d   = alu_op_q;
    mux1_d     = mux1_q;
    mux2_d     = mux2_q;
    mux3_d     = mux3_q;
    ex_rd_d    = ex_rd_q;
    ex_we_d    = ex_we_q;
    ex_load_d  = ex_load_q;
    mem_rd_d   = ex_rd_q;
    mem_we_d   = ex_we_q;
    stall      = 1'b0;
    if (!issue_slot) begin
      stall    = 1'b1;
      cnt_d    = cnt_q - CNT_W'(1);
      mem_rd_d = '0;
      mem_we_d = 1'b0;
    end else begin
      state_d    = RUN;
      ex_valid_d = 1'b0;
      alu_op_d   = ALU_NOP;
      mux1_d     = SEL_RF;
      mux2_d     = SEL_RF;
      mux3_d     = 1'b0;
      ex_rd_d    = '0;
      ex_we_d    = 1'b0;
      ex_load_d  = 1'b0;
      if (lu_hazard && !bus.flush_i) begin
        stall   = 1'b1;
        state_d = LU_STALL;
      end else if (bus.id_valid_i && !bus.flush_i) begin
        ex_valid_d = 1'b1;
        alu_op_d   = bus.id_alu_op_i;
        mux1_d     = fwd1;
        mux2_d     = fwd2;
        mux3_d     = bus.id_use_imm_i;
        ex_rd_d    = bus.id_rd_i;
        ex_we_d    = bus.id_we_i;
        ex_load_d  = bus.id_load_i;
        if (bus.id_mc_i) begin
          state_d = MC_BUSY;
          cnt_d   = CNT_W'(MC_CYCLES - 1);
        end
      end
    end
    mc_done_d = (state_d == MC_BUSY) && (cnt_d == CNT_W'(1));
  end

`ifdef EX_ISSUE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d, perf_mc_q, perf_mc_d;

  always_comb begin
    perf_lu_d = perf_lu_q;
    perf_mc_d = perf_mc_q;
    if (stall && (state_q != MC_BUSY) && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + PERF_W'(1);
    if (stall && (state_q == MC_BUSY) && (perf_mc_q != '1)) perf_mc_d = perf_mc_q + PERF_W'(1);
  end

  assign bus.perf_lu_stalls_o = perf_lu_q;
  assign bus.perf_mc_stalls_o = perf_mc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      ex_valid_q <= 1'b0;
      alu_op_q   <= ALU_NOP;
      mux1_q     <= SEL_RF;
      mux2_q     <= SEL_RF;
      mux3_q     <= 1'b0;
      mc_done_q  <= 1'b0;
      ex_rd_q    <= '0;
      ex_we_q    <= 1'b0;
      ex_load_q  <= 1'b0;
      mem_rd_q   <= '0;
      mem_we_q   <= 1'b0;
`ifdef EX_ISSUE_CTRL_PERF_EN
      perf_lu_q  <= '0;
      perf_mc_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_valid_q <= ex_valid_d;
      alu_op_q   <= alu_op_d;
      mux1_q     <= mux1_d;
      mux2_q     <= mux2_d;
      mux3_q     <= mux3_d;
      mc_done_q  <= mc_done_d;
      ex_rd_q    <= ex_rd_d;
      ex_we_q    <= ex_we_d;
      ex_load_q  <= ex_load_d;
      mem_rd_q   <= mem_rd_d;
      mem_we_q   <= mem_we_d;
`ifdef EX_ISSUE_CTRL_PERF_EN
      perf_lu_q  <= perf_lu_d;
      perf_mc_q  <= perf_mc_d;
`endif
    end
  end

  assign bus.stall_o    = stall;
  assign bus.ex_valid_o = ex_valid_q;
  assign bus.alu_op_o   = alu_op_q;
  assign bus.mux1_o     = mux1_q;
  assign bus.mux2_o     = mux2_q;
  assign bus.mux3_o     = mux3_q;
  assign bus.mc_done_o  = mc_done_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb/tb_ex_issue_ctrl.sv - scoreboard bench: directed hazard sequences then random instruction stream
module tb_ex_issue_ctrl;

  localparam int MC = 4;

  typedef struct packed {
    bit       valid;
    bit [4:0] rs1, rs2, rd;
    bit       we, ld, imm, mc, flush;
    bit [4:0] op;
  } instr_t;

  typedef struct packed {
    bit       v;
    bit [4:0] op;
    bit [1:0] m1, m2;
    bit       m3;
    bit [4:0] rd;
    bit       we, ld;
  } ex_t;

  typedef struct packed {
    bit       st, v;
    bit [4:0] op;
    bit [1:0] m1, m2;
    bit       m3, done;
  } exp_t;

  logic clk, rst;
  ex_issue_ctrl_if bus ();

  ex_issue_ctrl #(.MC_CYCLES(MC)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0, cycles = 0;
  bit mon_en = 1'b0;
  exp_t expq[$];
  instr_t prog[$];

  ex_t      m_ex;
  bit [4:0] m_mem_rd;
  bit       m_mem_we;
  int       m_hold, m_lu_cnt, m_mc_cnt;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] fwd(input bit [4:0] rs);
    if (rs == 0) return 2'b00;
    if (m_ex.we && m_ex.rd == rs) return 2'b10;
    if (m_mem_we && m_mem_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic instr_t mk(input bit [4:0] rd, rs1, rs2, input bit ld, imm, mcop, fl);
    instr_t i;
    i.valid = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.we = 1'b1;
    i.ld = ld; i.imm = imm; i.mc = mcop; i.flush = fl;
    i.op = mcop ? 5'd16 : (ld ? 5'd8 : 5'd1);
    return i;
  endfunction

  function automatic instr_t rnd();
    instr_t i;
    i.valid = ($urandom_range(9) < 8);
    i.rs1   = 5'($urandom_range(7));
    i.rs2   = 5'($urandom_range(7));
    i.rd    = 5'($urandom_range(7));
    i.ld    = ($urandom_range(3) == 0);
    i.mc    = !i.ld && ($urandom_range(7) == 0);
    i.we    = i.ld || ($urandom_range(4) != 0);
    i.imm   = ($urandom_range(2) == 0);
    i.flush = ($urandom_range(9) == 0);
    i.op    = 5'($urandom_range(31));
    return i;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem_rd = '0; m_mem_we = 1'b0; m_hold = 0; m_lu_cnt = 0; m_mc_cnt = 0;
  endtask

  task automatic drive(input instr_t i);
    bus.id_valid_i   = i.valid;
    bus.id_rs1_i     = i.rs1;
    bus.id_rs2_i     = i.rs2;
    bus.id_rd_i      = i.rd;
    bus.id_we_i      = i.we;
    bus.id_load_i    = i.ld;
    bus.id_use_imm_i = i.imm;
    bus.id_mc_i      = i.mc;
    bus.id_alu_op_i  = i.op;
    bus.flush_i      = i.flush;
  endtask

  // Called at posedge+1; records what this cycle must show, advances the model, waits one clock
  task automatic step(input instr_t i, output bit stalled);
    exp_t e;
    ex_t  nx;
    bit   haz;
    drive(i);
    e = '{st: 1'b0, v: m_ex.v, op: m_ex.op, m1: m_ex.m1, m2: m_ex.m2, m3: m_ex.m3,
          done: (m_hold == 1)};
    if (m_hold > 0) begin
      e.st = 1'b1; m_mc_cnt++; m_hold--;
      m_mem_rd = '0; m_mem_we = 1'b0;
    end else begin
      haz = i.valid && m_ex.ld && (m_ex.rd != 0) &&
            ((i.rs1 == m_ex.rd) || (!i.imm && i.rs2 == m_ex.rd));
      nx = '0;
      if (haz && !i.flush) begin
        e.st = 1'b1; m_lu_cnt++;
      end else if (i.valid && !i.flush) begin
        nx = '{v: 1'b1, op: i.op, m1: fwd(i.rs1), m2: fwd(i.rs2), m3: i.imm,
               rd: i.rd, we: i.we, ld: i.ld};
        if (i.mc) m_hold = MC - 1;
      end
      m_mem_rd = m_ex.rd; m_mem_we = m_ex.we;
      m_ex = nx;
    end
    expq.push_back(e);
    stalled = e.st;
    cycles++;
    @(posedge clk); #1;
  endtask

  task automatic run_prog();
    bit s;
    while (prog.size() > 0) begin
      if (cycles > 20000) begin
        chk("cycle_budget", cycles, 20000);
        prog.delete();
        break;
      end
      step(prog[0], s);
      if (!s || prog[0].flush) void'(prog.pop_front());
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ex_valid"}, int'(bus.ex_valid_o), 0);
    chk({tag, "_alu_op"},   int'(bus.alu_op_o), 0);
    chk({tag, "_mux1"},     int'(bus.mux1_o), 0);
    chk({tag, "_mux2"},     int'(bus.mux2_o), 0);
    chk({tag, "_mux3"},     int'(bus.mux3_o), 0);
    chk({tag, "_mc_done"},  int'(bus.mc_done_o), 0);
    chk({tag, "_stall"},    int'(bus.stall_o), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("stall_o",    int'(bus.stall_o), int'(e.st));
        chk("ex_valid_o", int'(bus.ex_valid_o), int'(e.v));
        chk("alu_op_o",   int'(bus.alu_op_o), int'(e.op));
        chk("mux1_o",     int'(bus.mux1_o), int'(e.m1));
        chk("mux2_o",     int'(bus.mux2_o), int'(e.m2));
        chk("mux3_o",     int'(bus.mux3_o), int'(e.m3));
        chk("mc_done_o",  int'(bus.mc_done_o), int'(e.done));
      end
    end
  end

  initial begin
    instr_t idle;
    bit s;
    idle = '0;
    drive(idle);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // EX/MEM forwarding, then x5 produced in both EX and MEM
    prog.push_back(mk(5, 1, 2, 0, 0, 0, 0));
    prog.push_back(mk(6, 5, 1, 0, 0, 0, 0));
    prog.push_back(mk(5, 1, 2, 0, 0, 0, 0));
    prog.push_back(mk(5, 3, 2, 0, 0, 0, 0));
    prog.push_back(mk(9, 5, 0, 0, 0, 0, 0));
    // load-use stall, then rs2 masked by immediate
    prog.push_back(mk(7, 1, 2, 1, 0, 0, 0));
    prog.push_back(mk(8, 7, 2, 0, 0, 0, 0));
    prog.push_back(mk(7, 1, 2, 1, 0, 0, 0));
    prog.push_back(mk(8, 3, 7, 0, 1, 0, 0));
    // multi-cycle single, then back-to-back
    prog.push_back(mk(10, 1, 2, 0, 0, 1, 0));
    prog.push_back(mk(11, 10, 1, 0, 0, 0, 0));
    prog.push_back(mk(12, 1, 2, 0, 0, 1, 0));
    prog.push_back(mk(13, 12, 2, 0, 0, 1, 0));
    prog.push_back(mk(14, 13, 12, 0, 0, 0, 0));
    // x0 never forwards; flush beats a load-use hazard
    prog.push_back(mk(0, 1, 2, 0, 0, 0, 0));
    prog.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    prog.push_back(mk(7, 1, 2, 1, 0, 0, 0));
    prog.push_back(mk(8, 7, 2, 0, 0, 0, 1));
    prog.push_back(mk(3, 1, 2, 0, 0, 0, 0));
    run_prog();

    // asynchronous reset while a multi-cycle op holds EX
    step(mk(10, 1, 2, 0, 0, 1, 0), s);
    step(mk(11, 10, 1, 0, 0, 0, 0), s);
    chk("pre_reset_stall", int'(bus.stall_o), 1);
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    model_reset();
    expq.push_back('0);
    cycles++;
    @(posedge clk); #1;
    rst = 1'b0;
    prog.push_back(mk(4, 1, 2, 0, 0, 0, 0));
    prog.push_back(mk(5, 4, 4, 0, 0, 0, 0));
    run_prog();

    for (int n = 0; n < 1500; n++) prog.push_back(rnd());
    run_prog();
    drive(idle);

`ifdef EX_ISSUE_CTRL_PERF_EN
    chk("perf_lu_stalls", int'(bus.perf_lu_stalls_o), m_lu_cnt);
    chk("perf_mc_stalls", int'(bus.perf_mc_stalls_o), m_mc_cnt);
`endif
    chk("scoreboard_drained", expq.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
